// File: rtl/fifo_seq_checker.sv
// Read-side consumer for a counter-fed FIFO: drains the read port and checks
// that consecutive words increment by one, keeping word/error statistics.
module fifo_seq_checker #(
    parameter int DW          = 20,
    parameter int RD_LAT      = 1,
    parameter int CW          = 16,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic          fifo_empty,
    output logic          fifo_re,
    input  logic [DW-1:0] fifo_q,
    output logic          synced,
    output logic [CW-1:0] word_cnt,
    output logic [CW-1:0] err_cnt,
    output logic          err,
    output logic [DW-1:0] first_err_data,
    output logic          halted,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        CHECK = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t              state;
    logic [DW-1:0]       expected;
    logic [RD_LAT-1:0]   vld_pipe;
    logic                vld;
    logic                mismatch;

    // Read handshake: a word is popped in every cycle where fifo_re is high,
    // which can only happen while the FIFO reports non-empty. The word for that
    // pop appears on fifo_q exactly RD_LAT cycles later, flagged by vld; no
    // backpressure exists on the return path, so every in-flight word is consumed.
    assign fifo_re   = en & ~fifo_empty & (state != HALT);
    assign vld       = vld_pipe[RD_LAT-1];
    assign mismatch  = (fifo_q != expected);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= SYNC;
            expected       <= '0;
            vld_pipe       <= '0;
            synced         <= 1'b0;
            word_cnt       <= '0;
            err_cnt        <= '0;
            err            <= 1'b0;
            first_err_data <= '0;
            halted         <= 1'b0;
        end else if (clr) begin
            // Flushing the pipe drops any word already on its way back.
            state          <= SYNC;
            expected       <= '0;
            vld_pipe       <= '0;
            synced         <= 1'b0;
            word_cnt       <= '0;
            err_cnt        <= '0;
            err            <= 1'b0;
            first_err_data <= '0;
            halted         <= 1'b0;
        end else begin
            vld_pipe[0] <= fifo_re;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end

            if (vld) begin
                if (word_cnt != {CW{1'b1}}) begin
                    word_cnt <= word_cnt + 1'b1;
                end

                if (state == SYNC) begin
                    expected <= fifo_q + 1'b1;
                    synced   <= 1'b1;
                    state    <= CHECK;
                end else if (!mismatch) begin
                    expected <= expected + 1'b1;
                end else begin
                    // Resynchronise to the received stream so one glitch counts once.
                    err      <= 1'b1;
                    expected <= fifo_q + 1'b1;
                    if (err_cnt != {CW{1'b1}}) begin
                        err_cnt <= err_cnt + 1'b1;
                    end
                    if (!err) begin
                        first_err_data <= fifo_q;
                    end
                    if (STOP_ON_ERR) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_seq_checker.sv
// Directed bench for fifo_seq_checker: two instances (latency 1 free-running,
// latency 2 stop-on-error) each fed by a small behavioural FIFO.
module tb_fifo_seq_checker;

    localparam int DW = 20;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic clr = 1'b0;

    // Instance 1: RD_LAT=1, STOP_ON_ERR=0
    logic          empty1 = 1'b1;
    logic          re1;
    logic [DW-1:0] q1 = '0;
    logic          synced1, err1, halted1;
    logic [CW-1:0] wcnt1, ecnt1;
    logic [DW-1:0] ferr1;
    logic [1:0]    st1;

    // Instance 2: RD_LAT=2, STOP_ON_ERR=1
    logic          empty2 = 1'b1;
    logic          re2;
    logic [DW-1:0] q2_s1 = '0;
    logic [DW-1:0] q2 = '0;
    logic          synced2, err2, halted2;
    logic [CW-1:0] wcnt2, ecnt2;
    logic [DW-1:0] ferr2;
    logic [1:0]    st2;

    logic [DW-1:0] fifo1[$];
    logic [DW-1:0] fifo2[$];
    int            underflow = 0;
    int            re_cnt1   = 0;
    int            n_checks  = 0;
    int            n_pass    = 0;

    fifo_seq_checker #(.DW(DW), .RD_LAT(1), .CW(CW), .STOP_ON_ERR(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .fifo_empty(empty1), .fifo_re(re1), .fifo_q(q1),
        .synced(synced1), .word_cnt(wcnt1), .err_cnt(ecnt1), .err(err1),
        .first_err_data(ferr1), .halted(halted1), .dbg_state(st1)
    );

    fifo_seq_checker #(.DW(DW), .RD_LAT(2), .CW(CW), .STOP_ON_ERR(1'b1)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .fifo_empty(empty2), .fifo_re(re2), .fifo_q(q2),
        .synced(synced2), .word_cnt(wcnt2), .err_cnt(ecnt2), .err(err2),
        .first_err_data(ferr2), .halted(halted2), .dbg_state(st2)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- FIFO models ----------------
    always @(posedge clk) begin
        if (re1) begin
            re_cnt1++;
            if (fifo1.size() == 0) underflow++;
            else q1 <= fifo1.pop_front();
        end
        empty1 <= (fifo1.size() == 0);
    end

    always @(posedge clk) begin
        if (re2) begin
            if (fifo2.size() == 0) underflow++;
            else q2_s1 <= fifo2.pop_front();
        end
        q2     <= q2_s1;
        empty2 <= (fifo2.size() == 0);
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push1(input logic [DW-1:0] v);
        fifo1.push_back(v);
    endtask

    task automatic push2(input logic [DW-1:0] v);
        fifo2.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(1);
    endtask

    // ---------------- stimulus ----------------
    int re_start;

    initial begin
        cycles(2);
        // Reset values with rst still asserted
        check("rst_re1",     re1,    0);
        check("rst_wcnt1",   wcnt1,  0);
        check("rst_ecnt1",   ecnt1,  0);
        check("rst_synced1", synced1, 0);
        check("rst_ferr1",   ferr1,  0);
        check("rst_halted2", halted2, 0);
        check("rst_state2",  st2,    0);
        rst = 1'b0;
        en  = 1'b1;
        cycles(1);

        // Clean run 0..9: one pop per clock
        re_start = re_cnt1;
        for (int i = 0; i < 10; i++) push1(DW'(i));
        cycles(15);
        check("run_re_cycles", re_cnt1 - re_start, 10);
        check("run_wcnt",   wcnt1,   10);
        check("run_ecnt",   ecnt1,   0);
        check("run_err",    err1,    0);
        check("run_synced", synced1, 1);
        check("run_state",  st1,     1);

        // Gap in the sequence: 5,6,7,9,10
        do_reset();
        push1(20'd5); push1(20'd6); push1(20'd7); push1(20'd9); push1(20'd10);
        cycles(10);
        check("gap_err",  err1,  1);
        check("gap_ecnt", ecnt1, 1);
        check("gap_ferr", ferr1, 20'd9);
        check("gap_wcnt", wcnt1, 5);

        // Wrap-around through 2^DW-1
        do_reset();
        push1(20'hFFFFE); push1(20'hFFFFF); push1(20'h00000); push1(20'h00001);
        cycles(10);
        check("wrap_ecnt", ecnt1, 0);
        check("wrap_err",  err1,  0);
        check("wrap_wcnt", wcnt1, 4);

        // Stop-on-error with two-cycle read latency: 1,2,4,5,6 read, 7,8 left behind
        do_reset();
        push2(20'd1); push2(20'd2); push2(20'd4); push2(20'd5);
        push2(20'd6); push2(20'd7); push2(20'd8);
        cycles(15);
        check("halt_halted", halted2, 1);
        check("halt_state",  st2,     2);
        check("halt_re",     re2,     0);
        check("halt_empty",  empty2,  0);
        check("halt_ecnt",   ecnt2,   1);
        check("halt_ferr",   ferr2,   20'd4);
        check("halt_wcnt",   wcnt2,   5);
        check("halt_left",   fifo2.size(), 2);

        // en low with data waiting, then resume
        fifo2.delete();
        do_reset();
        en = 1'b0;
        for (int i = 0; i < 4; i++) push1(DW'(100 + i));
        cycles(5);
        check("en_low_re",   re1,   0);
        check("en_low_wcnt", wcnt1, 0);
        en = 1'b1;
        cycles(8);
        check("en_resume_wcnt", wcnt1, 4);
        check("en_resume_err",  err1,  0);

        // Asynchronous reset mid-run, sampled away from any clock edge
        do_reset();
        push1(20'd40); push1(20'd41); push1(20'd42);
        cycles(6);
        check("pre_rst_wcnt", wcnt1, 3);
        #2 rst = 1'b1;
        #1;
        check("async_rst_wcnt",   wcnt1,   0);
        check("async_rst_synced", synced1, 0);
        check("async_rst_state",  st1,     0);
        cycles(1);
        rst = 1'b0;
        cycles(1);

        // clr after an error, then re-seed from an arbitrary word
        push1(20'd0); push1(20'd1); push1(20'd3);
        cycles(8);
        check("clr_pre_err",  err1,  1);
        check("clr_pre_ecnt", ecnt1, 1);
        clr = 1'b1;
        cycles(1);
        clr = 1'b0;
        check("clr_err",    err1,    0);
        check("clr_ecnt",   ecnt1,   0);
        check("clr_synced", synced1, 0);
        check("clr_wcnt",   wcnt1,   0);
        check("clr_ferr",   ferr1,   0);
        push1(20'd7);
        cycles(5);
        check("reseed_synced", synced1, 1);
        check("reseed_err",    err1,    0);
        check("reseed_wcnt",   wcnt1,   1);
        push1(20'd8);
        cycles(5);
        check("reseed_next_wcnt", wcnt1, 2);
        check("reseed_next_err",  err1,  0);

        check("no_underflow", underflow, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
